sort_window_3x3_linebuf: RTL and testbench

//  Upstream stage of the 3x3 sorting network. Accepts a raster-order stream of 8-bit pixels.
//  Two on-chip line buffers plus a 3x3 shift window produce one registered window per valid

---
 rtl/sort_window_3x3_linebuf.sv | 130 +++++++++++++
 tb/tb_sort_window_3x3_linebuf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sort_window_3x3_linebuf.sv
// Raster-order pixel stream to 3x3 neighbourhood windows (x1..x9) for the max/med/min sorter.
// Two line buffers feed a column shift window; only fully-populated windows are emitted.
module sort_window_3x3_linebuf #(
   parameter int PIX_W      = 8,
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             S_AXI_ACLK,
   input  logic             S_AXI_ARESETN,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic             pix_ready,
   output logic [PIX_W-1:0] win_x1,
   output logic [PIX_W-1:0] win_x2,
   output logic [PIX_W-1:0] win_x3,
   output logic [PIX_W-1:0] win_x4,
   output logic [PIX_W-1:0] win_x5,
   output logic [PIX_W-1:0] win_x6,
   output logic [PIX_W-1:0] win_x7,
   output logic [PIX_W-1:0] win_x8,
   output logic [PIX_W-1:0] win_x9,
   output logic             win_valid,
   input  logic             win_ready,
   output logic             frame_done
);

   logic [COL_W-1:0] col, eff_col;
   logic [ROW_W-1:0] row, eff_row;
   logic             acc, emit, last_col, last_row;

   logic [PIX_W-1:0] lb1 [IMG_WIDTH];
   logic [PIX_W-1:0] lb2 [IMG_WIDTH];
   logic [PIX_W-1:0] top_pix, mid_pix;

   // Window slots 0..8 map to x1..x9.
   logic [PIX_W-1:0] win_q   [9];
   logic [PIX_W-1:0] win_d   [9];
   logic [PIX_W-1:0] win_out [9];

   // One-entry output register: a new pixel may enter whenever the slot is free or draining.
   assign pix_ready = ~win_valid | win_ready;
   assign acc       = pix_valid & pix_ready;

   // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
   assign eff_col  = pix_sof ? '0 : col;
   assign eff_row  = pix_sof ? '0 : row;
   assign last_col = (eff_col == COL_W'(IMG_WIDTH - 1));
   assign last_row = (eff_row == ROW_W'(IMG_HEIGHT - 1));
   assign emit     = acc & (eff_col >= COL_W'(2)) & (eff_row >= ROW_W'(2));

   assign top_pix = lb2[eff_col];
   assign mid_pix = lb1[eff_col];

   // NOTE: every signal written here gets its value on every path, so no latch is inferred.
   always_comb begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top_pix;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid_pix;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
   end

   // NOTE: line-buffer RAM is deliberately not reset; the row/col gating on emit keeps stale
   // contents from ever reaching the outputs, and an unreset array maps onto block RAM.
   always_ff @(posedge S_AXI_ACLK) begin
      if (acc) begin
         lb2[eff_col] <= lb1[eff_col];
         lb1[eff_col] <= pix_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= acc & last_col & last_row;
         if (acc) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : eff_row + ROW_W'(1);
            end else begin
               col <= eff_col + COL_W'(1);
               row <= eff_row;
            end
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else if (acc) begin
         for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
      end
   end

   // A drain and a new emit in the same cycle simply reload the register with valid held high.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         win_valid <= 1'b0;
         for (int i = 0; i < 9; i++) win_out[i] <= '0;
      end else if (emit) begin
         win_valid <= 1'b1;
         for (int i = 0; i < 9; i++) win_out[i] <= win_d[i];
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end

   assign win_x1 = win_out[0];
   assign win_x2 = win_out[1];
   assign win_x3 = win_out[2];
   assign win_x4 = win_out[3];
   assign win_x5 = win_out[4];
   assign win_x6 = win_out[5];
   assign win_x7 = win_out[6];
   assign win_x8 = win_out[7];
   assign win_x9 = win_out[8];

endmodule

// File: tb/tb_sort_window_3x3_linebuf.sv
// Bench for sort_window_3x3_linebuf on a 4x4 image: a frame-image model predicts every window
// and frame_done pulse; literal windows pin the model for each directed scenario.
module tb_sort_window_3x3_linebuf;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pix_in = '0;
   logic       pix_valid = 1'b0;
   logic       pix_sof = 1'b0;
   logic       pix_ready;
   logic [7:0] win_x1, win_x2, win_x3, win_x4, win_x5, win_x6, win_x7, win_x8, win_x9;
   logic       win_valid;
   logic       win_ready = 1'b1;
   logic       frame_done;

   sort_window_3x3_linebuf #(.PIX_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
      .win_x1(win_x1), .win_x2(win_x2), .win_x3(win_x3),
      .win_x4(win_x4), .win_x5(win_x5), .win_x6(win_x6),
      .win_x7(win_x7), .win_x8(win_x8), .win_x9(win_x9),
      .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [71:0] pack9(input int a, b, c, d, e, f, g, h, i);
      logic [7:0] v [9];
      v = '{a[7:0], b[7:0], c[7:0], d[7:0], e[7:0], f[7:0], g[7:0], h[7:0], i[7:0]};
      return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], v[8]};
   endfunction

   wire [71:0] cur_win = {win_x1, win_x2, win_x3, win_x4, win_x5, win_x6, win_x7, win_x8, win_x9};

   // Model: the image as written so far, the next raster position, and the pending windows.
   logic [7:0]  img [H][W];
   int          mcol = 0, mrow = 0;
   logic [71:0] expq [$];
   logic [71:0] logq [$];
   logic        fd_exp = 1'b0;
   int          fd_cnt = 0;
   logic        hold = 1'b0;
   logic [71:0] held = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         mcol = 0; mrow = 0; fd_exp = 1'b0; hold = 1'b0;
      end else begin
         check("frame_done", frame_done, fd_exp);
         if (frame_done) fd_cnt++;
         check("pix_ready", pix_ready, !win_valid || win_ready);
         if (hold) begin
            check("hold_valid", win_valid, 1'b1);
            check("hold_data", cur_win, held);
         end
         if (win_valid && win_ready) begin
            if (expq.size() == 0) check("spurious_window", win_valid, 1'b0);
            else check("window", cur_win, expq.pop_front());
            logq.push_back(cur_win);
         end
         hold = win_valid && !win_ready;
         held = cur_win;
         fd_exp = 1'b0;
         if (pix_valid && pix_ready) begin
            if (pix_sof) begin mcol = 0; mrow = 0; end
            img[mrow][mcol] = pix_in;
            if (mrow >= 2 && mcol >= 2)
               expq.push_back({img[mrow-2][mcol-2], img[mrow-2][mcol-1], img[mrow-2][mcol],
                               img[mrow-1][mcol-2], img[mrow-1][mcol-1], img[mrow-1][mcol],
                               img[mrow][mcol-2],   img[mrow][mcol-1],   img[mrow][mcol]});
            if (mcol == W - 1) begin
               mcol = 0;
               if (mrow == H - 1) begin mrow = 0; fd_exp = 1'b1; end
               else mrow++;
            end else mcol++;
         end
      end
   end

   task automatic send(input int p, input bit sof, input bit bubble);
      int n = 0;
      if (bubble) begin pix_valid = 1'b0; @(posedge clk); #1; end
      pix_in = p[7:0]; pix_sof = sof; pix_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (pix_ready) begin @(posedge clk); #1; break; end
         n++;
         if (n > 100) begin check("send_timeout", pix_ready, 1'b1); break; end
      end
      pix_valid = 1'b0; pix_sof = 1'b0;
   endtask

   task automatic ramp(input int base, input int count, input bit sof0, input bit bubbles);
      for (int k = 0; k < count; k++)
         send(base + k, sof0 && (k == 0), bubbles ? bit'($urandom_range(0, 1)) : 1'b0);
   endtask

   task automatic drain_and_clear(input string tag);
      win_ready = 1'b1; pix_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_drained"}, expq.size(), 0);
   endtask

   task automatic start_test;
      logq.delete(); fd_cnt = 0;
   endtask

   task automatic check_ramp(input string tag, input int idx0, input int b);
      check({tag, "_w0"}, logq[idx0],     pack9(b+0, b+1, b+2, b+4, b+5, b+6, b+8,  b+9,  b+10));
      check({tag, "_w1"}, logq[idx0 + 1], pack9(b+1, b+2, b+3, b+5, b+6, b+7, b+9,  b+10, b+11));
      check({tag, "_w2"}, logq[idx0 + 2], pack9(b+4, b+5, b+6, b+8, b+9, b+10, b+12, b+13, b+14));
      check({tag, "_w3"}, logq[idx0 + 3], pack9(b+5, b+6, b+7, b+9, b+10, b+11, b+13, b+14, b+15));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #12;
      check("rst_valid", win_valid, 1'b0);
      check("rst_window", cur_win, '0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_pix_ready", pix_ready, 1'b1);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: plain ramp
      start_test();
      ramp(0, 16, 1'b1, 1'b0);
      drain_and_clear("t1");
      check("t1_count", logq.size(), 4);
      check_ramp("t1", 0, 0);
      check("t1_fd", fd_cnt, 1);

      // 2: downstream stall of five cycles after the first window
      start_test();
      fork
         ramp(0, 16, 1'b1, 1'b0);
         begin
            int n = 0;
            while (!win_valid && n < 500) begin @(posedge clk); #1; n++; end
            check("t2_first_valid", win_valid, 1'b1);
            win_ready = 1'b0;
            repeat (5) begin
               #1 check("t2_ready_low", pix_ready, 1'b0);
               @(posedge clk); #1;
            end
            win_ready = 1'b1;
         end
      join
      drain_and_clear("t2");
      check("t2_count", logq.size(), 4);
      check_ramp("t2", 0, 0);

      // 3: random input bubbles
      start_test();
      ramp(0, 16, 1'b1, 1'b1);
      drain_and_clear("t3");
      check("t3_count", logq.size(), 4);
      check_ramp("t3", 0, 0);

      // 4: partial frame abandoned by sof
      start_test();
      ramp(200, 6, 1'b0, 1'b0);
      send(50, 1'b1, 1'b0);
      ramp(100, 15, 1'b0, 1'b0);
      drain_and_clear("t4");
      check("t4_count", logq.size(), 4);
      check("t4_first", logq[0], pack9(50, 100, 101, 103, 104, 105, 107, 108, 109));
      check("t4_fd", fd_cnt, 1);

      // 5: asynchronous reset in row 2 with a window in the output register
      start_test();
      ramp(0, 11, 1'b1, 1'b0);
      check("t5_valid_before", win_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", win_valid, 1'b0);
      check("t5_rst_window", cur_win, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      start_test();
      ramp(0, 16, 1'b0, 1'b0);
      drain_and_clear("t5");
      check("t5_count", logq.size(), 4);
      check_ramp("t5", 0, 0);

      // 6: two frames back to back without sof
      start_test();
      ramp(0, 32, 1'b0, 1'b0);
      drain_and_clear("t6");
      check("t6_count", logq.size(), 8);
      check_ramp("t6a", 0, 0);
      check("t6_w4", logq[4], pack9(16, 17, 18, 20, 21, 22, 24, 25, 26));
      check_ramp("t6b", 4, 16);
      check("t6_fd", fd_cnt, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
